// File: rtl/frame_draw_pkg.sv
// Shared types and constants for the frame draw scheduler.
// Source IDs give the fixed per-frame drawing order.
package frame_draw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      GRANT,
      DONE
   } sched_state_t;

   localparam int SOURCE_SEL_ADDRW_DEF = 2;

   localparam int SRC_BKG       = 0;
   localparam int SRC_STARFIELD = 1;
   localparam int SRC_GSENS_CAL = 2;

endpackage

// File: rtl/grant_watchdog.sv
// Per-grant hang detector: loads on grant, counts down while held.
// expired is high during the last allowed grant cycle.
module grant_watchdog #(
   parameter int TIMEOUT_CYCLES = 400000
) (
   input  logic clk,
   input  logic resetN,
   input  logic clr,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, then load, then decrement without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame write-bus sequencer: grants draw sources in index order,
// reports frame completion, counts overruns and flags hung sources.
module frame_draw_scheduler
   import frame_draw_pkg::*;
#(
   parameter int MAX_WRITE_SOURCE = 2,
   parameter int SOURCE_SEL_ADDRW = SOURCE_SEL_ADDRW_DEF,
   parameter int TIMEOUT_CYCLES   = 400000,
   parameter int OVR_CNT_W        = 8
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        frame,
   input  logic [MAX_WRITE_SOURCE:0]   src_req,
   input  logic [MAX_WRITE_SOURCE:0]   src_done,
   output logic [MAX_WRITE_SOURCE:0]   src_grant,
   output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
   output logic                        sched_busy,
   output logic                        frame_complete,
   output logic                        frame_overrun,
   output logic [OVR_CNT_W-1:0]        overrun_count,
   output logic                        timeout_err
);

   localparam int NSRC  = MAX_WRITE_SOURCE + 1;
   localparam int SEL_W = SOURCE_SEL_ADDRW;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(MAX_WRITE_SOURCE);

   sched_state_t         state_q, state_d;
   logic [SEL_W-1:0]     cur_idx_q, cur_idx_d;
   logic [NSRC-1:0]      grant_q, grant_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 busy_q, busy_d;
   logic                 complete_q, complete_d;
   logic                 overrun_q, overrun_d;
   logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
   logic                 timeout_q, timeout_d;

   logic wd_clr;
   logic wd_load;
   logic wd_en;
   logic wd_expired;

   grant_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetN (resetN),
      .clr    (wd_clr),
      .load   (wd_load),
      .en     (wd_en),
      .expired(wd_expired)
   );

   // Sequencer next-state: overrun restarts the walk, done or hang advances it.
   always_comb begin
      state_d    = state_q;
      cur_idx_d  = cur_idx_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      complete_d = complete_q;
      overrun_d  = 1'b0;
      ovr_cnt_d  = ovr_cnt_q;
      timeout_d  = timeout_q;
      wd_clr     = 1'b0;
      wd_load    = 1'b0;
      wd_en      = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (frame) begin
               state_d    = CHECK;
               cur_idx_d  = '0;
               busy_d     = 1'b1;
               complete_d = 1'b0;
            end
         end

         CHECK, GRANT: begin
            if (frame) begin
               state_d   = CHECK;
               cur_idx_d = '0;
               grant_d   = '0;
               overrun_d = 1'b1;
               wd_clr    = 1'b1;
               if (ovr_cnt_q != '1) begin
                  ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
               end
            end else if (state_q == CHECK) begin
               if (src_req[cur_idx_q]) begin
                  state_d = GRANT;
                  grant_d = NSRC'(1) << cur_idx_q;
                  sel_d   = cur_idx_q;
                  wd_load = 1'b1;
               end else if (cur_idx_q < LAST_IDX) begin
                  cur_idx_d = cur_idx_q + SEL_W'(1);
               end else begin
                  state_d    = DONE;
                  busy_d     = 1'b0;
                  complete_d = 1'b1;
               end
            end else begin
               wd_en = 1'b1;
               if (src_done[cur_idx_q] || wd_expired) begin
                  grant_d = '0;
                  wd_clr  = 1'b1;
                  if (!src_done[cur_idx_q]) begin
                     timeout_d = 1'b1;
                  end
                  if (cur_idx_q < LAST_IDX) begin
                     state_d   = CHECK;
                     cur_idx_d = cur_idx_q + SEL_W'(1);
                  end else begin
                     state_d    = DONE;
                     busy_d     = 1'b0;
                     complete_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All sequencer state and outputs are registered here.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q    <= IDLE;
         cur_idx_q  <= '0;
         grant_q    <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
         overrun_q  <= 1'b0;
         ovr_cnt_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_idx_q  <= cur_idx_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         complete_q <= complete_d;
         overrun_q  <= overrun_d;
         ovr_cnt_q  <= ovr_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign src_grant        = grant_q;
   assign write_source_sel = sel_q;
   assign sched_busy       = busy_q;
   assign frame_complete   = complete_q;
   assign frame_overrun    = overrun_q;
   assign overrun_count    = ovr_cnt_q;
   assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench for frame_draw_scheduler with a 16-cycle watchdog.
// Each task drives one scenario and checks against hand-derived values.
module tb_frame_draw_scheduler;

   logic       clk;
   logic       resetN;
   logic       frame;
   logic [2:0] src_req;
   logic [2:0] src_done;
   logic [2:0] src_grant;
   logic [1:0] write_source_sel;
   logic       sched_busy;
   logic       frame_complete;
   logic       frame_overrun;
   logic [7:0] overrun_count;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   frame_draw_scheduler #(
      .MAX_WRITE_SOURCE(2),
      .SOURCE_SEL_ADDRW(2),
      .TIMEOUT_CYCLES  (16),
      .OVR_CNT_W       (8)
   ) dut (
      .clk             (clk),
      .resetN          (resetN),
      .frame           (frame),
      .src_req         (src_req),
      .src_done        (src_done),
      .src_grant       (src_grant),
      .write_source_sel(write_source_sel),
      .sched_busy      (sched_busy),
      .frame_complete  (frame_complete),
      .frame_overrun   (frame_overrun),
      .overrun_count   (overrun_count),
      .timeout_err     (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      tick();
      tick();
      checks++;
      if (src_grant !== 3'b000) begin
         errors++;
         $display("FAIL reset_grant got %b want 000", src_grant);
      end
      checks++;
      if (write_source_sel !== 2'd0 || sched_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_sel_busy got %0d/%b want 0/0",
                  write_source_sel, sched_busy);
      end
      checks++;
      if (frame_complete !== 1'b0 || frame_overrun !== 1'b0 ||
          overrun_count !== 8'd0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got %b%b%0d%b want 0000",
                  frame_complete, frame_overrun, overrun_count, timeout_err);
      end
      resetN = 1'b1;
      tick();
      tick();
      checks++;
      if (sched_busy !== 1'b0 || src_grant !== 3'b000) begin
         errors++;
         $display("FAIL idle_hold got busy %b grant %b want 0 000",
                  sched_busy, src_grant);
      end
   endtask

   task automatic test_all_sources();
      int cyc;
      logic [2:0] eg;
      logic [1:0] es;
      src_req = 3'b111;
      pulse_frame();
      cyc = 1;
      checks++;
      if (sched_busy !== 1'b1 || src_grant !== 3'b000) begin
         errors++;
         $display("FAIL all_check0 got busy %b grant %b want 1 000",
                  sched_busy, src_grant);
      end
      for (int s = 0; s < 3; s++) begin
         eg = 3'b001 << s;
         es = 2'(s);
         tick();
         cyc++;
         for (int h = 0; h < 5; h++) begin
            checks++;
            if (src_grant !== eg || write_source_sel !== es) begin
               errors++;
               $display("FAIL all_grant s%0d h%0d got %b/%0d want %b/%0d",
                        s, h, src_grant, write_source_sel, eg, es);
            end
            if (h == 4) src_done = eg;
            tick();
            cyc++;
            src_done = 3'b000;
         end
         checks++;
         if (src_grant !== 3'b000) begin
            errors++;
            $display("FAIL all_drop s%0d got %b want 000", s, src_grant);
         end
      end
      checks++;
      if (frame_complete !== 1'b1 || sched_busy !== 1'b0 || cyc != 19) begin
         errors++;
         $display("FAIL all_complete got %b busy %b cyc %0d want 1 0 19",
                  frame_complete, sched_busy, cyc);
      end
      checks++;
      if (write_source_sel !== 2'd2) begin
         errors++;
         $display("FAIL all_sel_hold got %0d want 2", write_source_sel);
      end
   endtask

   task automatic test_skip();
      src_req = 3'b101;
      pulse_frame();
      checks++;
      if (frame_complete !== 1'b0) begin
         errors++;
         $display("FAIL skip_clear_complete got %b want 0", frame_complete);
      end
      tick();
      checks++;
      if (src_grant !== 3'b001) begin
         errors++;
         $display("FAIL skip_grant0 got %b want 001", src_grant);
      end
      src_done = 3'b001;
      tick();
      src_done = 3'b000;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (src_grant !== 3'b000) begin
            errors++;
            $display("FAIL skip_gap%0d got %b want 000", k, src_grant);
         end
         tick();
      end
      checks++;
      if (src_grant !== 3'b100 || write_source_sel !== 2'd2) begin
         errors++;
         $display("FAIL skip_grant2 got %b/%0d want 100/2",
                  src_grant, write_source_sel);
      end
      src_done = 3'b100;
      tick();
      src_done = 3'b000;
      checks++;
      if (frame_complete !== 1'b1) begin
         errors++;
         $display("FAIL skip_complete got %b want 1", frame_complete);
      end
   endtask

   task automatic test_timeout();
      src_req = 3'b111;
      pulse_frame();
      tick();
      src_done = 3'b001;
      tick();
      src_done = 3'b000;
      tick();
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (src_grant !== 3'b010 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hold k%0d got %b/%b want 010/0",
                     k, src_grant, timeout_err);
         end
         tick();
      end
      checks++;
      if (src_grant !== 3'b000 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_fire got %b/%b want 000/1",
                  src_grant, timeout_err);
      end
      tick();
      checks++;
      if (src_grant !== 3'b100 || write_source_sel !== 2'd2) begin
         errors++;
         $display("FAIL tmo_next got %b/%0d want 100/2",
                  src_grant, write_source_sel);
      end
      src_done = 3'b100;
      tick();
      src_done = 3'b000;
      checks++;
      if (frame_complete !== 1'b1 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_complete got %b/%b want 1/1",
                  frame_complete, timeout_err);
      end
   endtask

   task automatic test_overrun();
      src_req = 3'b111;
      pulse_frame();
      tick();
      src_done = 3'b001;
      tick();
      src_done = 3'b000;
      tick();
      checks++;
      if (src_grant !== 3'b010 || overrun_count !== 8'd0) begin
         errors++;
         $display("FAIL ovr_pre got %b/%0d want 010/0",
                  src_grant, overrun_count);
      end
      frame = 1'b1;
      src_done = 3'b010;
      tick();
      frame = 1'b0;
      src_done = 3'b000;
      checks++;
      if (frame_overrun !== 1'b1 || overrun_count !== 8'd1 ||
          src_grant !== 3'b000 || sched_busy !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse got %b/%0d/%b/%b want 1/1/000/1",
                  frame_overrun, overrun_count, src_grant, sched_busy);
      end
      tick();
      checks++;
      if (frame_overrun !== 1'b0 || src_grant !== 3'b001) begin
         errors++;
         $display("FAIL ovr_restart got %b/%b want 0/001",
                  frame_overrun, src_grant);
      end
   endtask

   task automatic test_reset_mid_grant();
      src_done = 3'b001;
      tick();
      src_done = 3'b000;
      tick();
      checks++;
      if (src_grant !== 3'b010 || write_source_sel !== 2'd1) begin
         errors++;
         $display("FAIL rmg_pre got %b/%0d want 010/1",
                  src_grant, write_source_sel);
      end
      resetN = 1'b0;
      frame = 1'b1;
      tick();
      resetN = 1'b1;
      frame = 1'b0;
      checks++;
      if (src_grant !== 3'b000 || write_source_sel !== 2'd0 ||
          sched_busy !== 1'b0) begin
         errors++;
         $display("FAIL rmg_bus got %b/%0d/%b want 000/0/0",
                  src_grant, write_source_sel, sched_busy);
      end
      checks++;
      if (overrun_count !== 8'd0 || timeout_err !== 1'b0 ||
          frame_complete !== 1'b0) begin
         errors++;
         $display("FAIL rmg_flags got %0d/%b/%b want 0/0/0",
                  overrun_count, timeout_err, frame_complete);
      end
      tick();
      checks++;
      if (sched_busy !== 1'b0) begin
         errors++;
         $display("FAIL rmg_frame_ignored got busy %b want 0", sched_busy);
      end
   endtask

   task automatic test_saturate();
      src_req = 3'b000;
      frame = 1'b1;
      tick();
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 200) begin
            checks++;
            if (overrun_count !== 8'd200) begin
               errors++;
               $display("FAIL sat_mid got %0d want 200", overrun_count);
            end
         end
      end
      checks++;
      if (overrun_count !== 8'd255 || frame_overrun !== 1'b1) begin
         errors++;
         $display("FAIL sat_top got %0d/%b want 255/1",
                  overrun_count, frame_overrun);
      end
      frame = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (frame_complete !== 1'b1 || overrun_count !== 8'd255 ||
          src_grant !== 3'b000) begin
         errors++;
         $display("FAIL sat_end got %b/%0d/%b want 1/255/000",
                  frame_complete, overrun_count, src_grant);
      end
   endtask

   initial begin
      resetN   = 1'b0;
      frame    = 1'b0;
      src_req  = 3'b000;
      src_done = 3'b000;
      test_reset();
      test_all_sources();
      test_skip();
      test_timeout();
      test_overrun();
      test_reset_mid_grant();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
